sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL provide parameter WORD_SIZE, default 8, data width of the SRAM word.
REQ-002 SHALL provide parameter ADDR_SIZE, default 8, SRAM address width (256 words).
REQ-003 SHALL provide parameter MAX_BURST, default 4, max back-to-back accesses granted to one requester while the other waits.
REQ-004 SHALL provide ports: clk  in  1  system clock, all logic on rising edge; rst  in  1  synchronous active-high reset.
REQ-005 SHALL provide ports: cpu_req  in  1  CPU access request; cpu_we  in  1  CPU write; cpu_addr  in  ADDR_SIZE; cpu_wdata  in  WORD_SIZE.
REQ-006 SHALL provide ports: cpu_gnt  out  1  CPU owns SRAM this cycle; cpu_ack  out  1  CPU access done, rdata valid.
REQ-007 SHALL provide ports: ldr_req  in  1; ldr_we  in  1; ldr_addr  in  ADDR_SIZE; ldr_wdata  in  WORD_SIZE; ldr_gnt  out  1; ldr_ack  out  1 (program loader/debug port, same meanings as CPU).
REQ-008 SHALL provide ports: rdata  out  WORD_SIZE  read data for the acked requester; cpu_stall  out  1  CPU has cpu_req high without ack this cycle.
REQ-009 SHALL provide ports: mem_en  out  1; mem_we  out  1; mem_addr  out  ADDR_SIZE; mem_wdata  out  WORD_SIZE; mem_rdata  in  WORD_SIZE  (single-port SRAM, registered read, data valid one cycle after mem_en).

Function
REQ-010 SHALL implement states IDLE, ACCESS, RESP; one access occupies ACCESS then RESP (2 cycles).
REQ-011 SHALL, in IDLE or RESP, sample requests at the edge and select an owner; selected owner's gnt and mem_en are high in the following cycle (ACCESS).
REQ-012 SHALL drive mem_addr/mem_we/mem_wdata from the owner's inputs during ACCESS only; mem_en, mem_we SHALL be 0 in all other states.
REQ-013 SHALL pulse owner's ack for exactly one cycle in RESP with rdata = mem_rdata; rdata SHALL hold its last value otherwise; writes also ack.
REQ-014 SHALL go RESP->ACCESS directly (back-to-back) if any request is pending, else RESP->IDLE; IDLE with no request stays IDLE.
REQ-015 SHALL keep the same owner for consecutive accesses while its req stays high, until MAX_BURST accesses complete and the other requester is waiting; then the other requester SHALL be granted.
REQ-016 SHALL reset the burst counter on owner change or on return to IDLE; counter SHALL saturate at MAX_BURST, never wrap.
REQ-017 SHALL complete an access whose req drops during ACCESS (write committed, ack still pulsed); no new grant to it afterwards.
REQ-018 SHALL never assert cpu_gnt and ldr_gnt together, nor cpu_ack and ldr_ack together.
REQ-019 SHALL assert cpu_stall = cpu_req & ~cpu_ack combinationally.

Reset
REQ-020 SHALL, on rst high at a clock edge, force IDLE, burst counter 0, last owner = loader, all outputs 0 (rdata 0) from the next cycle.
REQ-021 SHALL abort an in-flight access on reset mid-operation: no ack issued, mem_en low next cycle.
REQ-022 SHALL ignore requests in the reset cycle; first grant no earlier than 2 cycles after rst deasserts.

Configuration
REQ-023 SHALL, with macro SRAM_ARB_RR_EN defined, resolve simultaneous requests from IDLE round-robin: the requester that was not last owner wins (CPU first after reset).
REQ-024 SHALL, without SRAM_ARB_RR_EN, resolve simultaneous requests from IDLE by fixed priority: loader wins; REQ-015 burst limit applies in both builds.

Verification
REQ-025 SHALL cover: CPU read addr 130 holding 2, single request -> cpu_gnt+mem_en 1 cycle after sampling, cpu_ack with rdata=2 next cycle, total 2 cycles.
REQ-026 SHALL cover: loader writes 139<=8'hF0 then CPU reads 139 -> CPU rdata=8'hF0, no overlapping gnt.
REQ-027 SHALL cover: both req held continuously, MAX_BURST=4 -> owner alternates every 4 acks; fixed build starts loader, RR build starts CPU.
REQ-028 SHALL cover: rst asserted during ACCESS of a CPU write to 131 -> no cpu_ack, mem_en 0 next cycle, all outputs 0, state IDLE.
REQ-029 SHALL cover: CPU drops req during ACCESS of write 128<=6 -> memory[128]=6, one cpu_ack, return to IDLE, cpu_stall 0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: bundles every non-clock signal of the SRAM arbiter.
// It carries the two requesters (CPU and program loader), the shared read
// data and CPU stall, and the single-port SRAM side.
//   slave  : used by the arbiter. It takes in the requests and mem_rdata,
//            and drives the grants, acks, rdata, cpu_stall and mem_*.
//   master : used by the environment. It drives the requests and acts as
//            the SRAM by driving mem_rdata.
// Parameters: WORD_SIZE (data width), ADDR_SIZE (address width).
interface sram_arbiter_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8
);
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_ack;

  logic                 ldr_req;
  logic                 ldr_we;
  logic [ADDR_SIZE-1:0] ldr_addr;
  logic [WORD_SIZE-1:0] ldr_wdata;
  logic                 ldr_gnt;
  logic                 ldr_ack;

  logic [WORD_SIZE-1:0] rdata;
  logic                 cpu_stall;

  logic                 mem_en;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata,
    output cpu_gnt, cpu_ack, ldr_gnt, ldr_ack,
    output rdata, cpu_stall,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata,
    input  cpu_gnt, cpu_ack, ldr_gnt, ldr_ack,
    input  rdata, cpu_stall,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between a CPU and a program
// loader. The SRAM has a registered read, so read data arrives one cycle
// after mem_en.
//
// Each access takes two cycles:
//   ACCESS : the owner's gnt and mem_en are high.
//   RESP   : the owner's ack is high and rdata carries mem_rdata.
// If another request is pending, RESP goes straight back into ACCESS.
// One owner keeps the SRAM while its request stays high. After MAX_BURST
// accesses in a row, it hands over if the other requester is waiting.
//
// Ports:
//   clk : rising-edge clock.
//   rst : synchronous, active-high reset.
//   bus : sram_arbiter_if.slave, carrying the requester and SRAM signals.
//
// Build option: macro SRAM_ARB_RR_EN.
//   Defined   : ties seen from IDLE go to whoever was not the last owner.
//   Undefined : ties seen from IDLE go to the loader.
module sram_arbiter #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  owner_t               last_q,  last_d;
  logic [CNT_W-1:0]     burst_q, burst_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  // Set by reset, cleared one cycle later. Keeps the first grant at least
  // two cycles after reset is released.
  logic                 init_q;

  logic                 own_req, oth_req;
  logic                 own_is_cpu;
  owner_t               tie_winner;
  logic                 sel_we;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [WORD_SIZE-1:0] sel_wdata;
  logic                 in_access, in_resp;

  // Counts accesses in the current run and holds at MAX_BURST.
  function automatic logic [CNT_W-1:0] burst_inc(input logic [CNT_W-1:0] c);
    if (c >= BURST_MAX) return BURST_MAX;
    return c + BURST_ONE;
  endfunction

`ifdef SRAM_ARB_RR_EN
  assign tie_winner = owner_t'(~last_q);
`else
  assign tie_winner = OWN_LDR;
`endif

  assign own_is_cpu = (owner_q == OWN_CPU);
  assign own_req    = own_is_cpu ? bus.cpu_req : bus.ldr_req;
  assign oth_req    = own_is_cpu ? bus.ldr_req : bus.cpu_req;
  assign sel_we     = own_is_cpu ? bus.cpu_we    : bus.ldr_we;
  assign sel_addr   = own_is_cpu ? bus.cpu_addr  : bus.ldr_addr;
  assign sel_wdata  = own_is_cpu ? bus.cpu_wdata : bus.ldr_wdata;
  assign in_access  = (state_q == ACCESS);
  assign in_resp    = (state_q == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_LDR;
      last_q  <= OWN_LDR;
      burst_q <= '0;
      rdata_q <= '0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      rdata_q <= rdata_d;
      init_q  <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (!init_q && (bus.cpu_req || bus.ldr_req)) begin
          state_d = ACCESS;
          burst_d = BURST_ONE;
          if (bus.cpu_req && bus.ldr_req) owner_d = tie_winner;
          else if (bus.cpu_req)           owner_d = OWN_CPU;
          else                            owner_d = OWN_LDR;
          last_d = owner_d;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rdata_d = bus.mem_rdata;
        // The owner keeps going unless it has used up its burst while the
        // other requester waits.
        if (own_req && !(oth_req && (burst_q >= BURST_MAX))) begin
          state_d = ACCESS;
          burst_d = burst_inc(burst_q);
        end else if (oth_req) begin
          state_d = ACCESS;
          owner_d = owner_t'(~owner_q);
          last_d  = owner_t'(~owner_q);
          burst_d = BURST_ONE;
        end else begin
          state_d = IDLE;
          burst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cpu_gnt   = in_access && own_is_cpu;
  assign bus.ldr_gnt   = in_access && !own_is_cpu;
  assign bus.cpu_ack   = in_resp && own_is_cpu;
  assign bus.ldr_ack   = in_resp && !own_is_cpu;
  assign bus.mem_en    = in_access;
  assign bus.mem_we    = in_access && sel_we;
  assign bus.mem_addr  = in_access ? sel_addr  : '0;
  assign bus.mem_wdata = in_access ? sel_wdata : '0;
  assign bus.rdata     = in_resp ? bus.mem_rdata : rdata_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter. It plays the CPU, the
// loader and a registered-read SRAM. Inputs change on the falling edge and
// outputs are checked on the falling edge.
module tb_sram_arbiter;
  localparam int WS = 8;
  localparam int AS = 8;
  localparam int MB = 4;
`ifdef SRAM_ARB_RR_EN
  localparam logic FIRST_LDR = 1'b0;
`else
  localparam logic FIRST_LDR = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if #(.WORD_SIZE(WS), .ADDR_SIZE(AS)) bus ();

  sram_arbiter #(.WORD_SIZE(WS), .ADDR_SIZE(AS), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM with a registered read. Location 130 is seeded with 2.
  logic [WS-1:0] mem [256];
  logic [WS-1:0] mem_rdata_q = '0;
  always @(posedge clk) begin
    if (rst) mem[130] <= 8'd2;
    else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            mem_rdata_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rdata_q;

  int n_chk = 0;
  int n_err = 0;
  int n_cpu_ack = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cgnt"}, 32'(bus.cpu_gnt), 0);
    chk({tag, "_lgnt"}, 32'(bus.ldr_gnt), 0);
    chk({tag, "_cack"}, 32'(bus.cpu_ack), 0);
    chk({tag, "_lack"}, 32'(bus.ldr_ack), 0);
    chk({tag, "_men"},  32'(bus.mem_en),  0);
    chk({tag, "_mwe"},  32'(bus.mem_we),  0);
  endtask

  // Mutual exclusion of the grants and of the acks, checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("gnt_excl", 32'(bus.cpu_gnt & bus.ldr_gnt), 0);
      chk("ack_excl", 32'(bus.cpu_ack & bus.ldr_ack), 0);
    end
    if (bus.cpu_ack) n_cpu_ack++;
  end

  initial begin
    int k;
    int ack0;
    logic exp_ldr;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;

    // Reset state.
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_maddr", 32'(bus.mem_addr), 0);

    // A request held through the last reset edge must be ignored. The
    // first grant comes two cycles after release: a CPU read of 130.
    bus.cpu_req = 1; bus.cpu_addr = 8'd130;
    @(negedge clk);
    chk_quiet("rstreq");
    chk("rstreq_stall", 32'(bus.cpu_stall), 1);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("guard");
    @(negedge clk);
    chk("rd_gnt",   32'(bus.cpu_gnt), 1);
    chk("rd_men",   32'(bus.mem_en), 1);
    chk("rd_mwe",   32'(bus.mem_we), 0);
    chk("rd_maddr", 32'(bus.mem_addr), 130);
    chk("rd_stall", 32'(bus.cpu_stall), 1);
    @(negedge clk);
    chk("rd_ack",    32'(bus.cpu_ack), 1);
    chk("rd_rdata",  32'(bus.rdata), 2);
    chk("rd_stall2", 32'(bus.cpu_stall), 0);
    chk("rd_men2",   32'(bus.mem_en), 0);
    bus.cpu_req = 0;
    @(negedge clk);
    chk_quiet("rd_idle");
    chk("rd_hold", 32'(bus.rdata), 2);

    // Loader writes 139 <= F0, then the CPU reads it back.
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 8'd139; bus.ldr_wdata = 8'hF0;
    @(negedge clk);
    chk("lw_gnt",  32'(bus.ldr_gnt), 1);
    chk("lw_mwe",  32'(bus.mem_we), 1);
    chk("lw_addr", 32'(bus.mem_addr), 139);
    chk("lw_data", 32'(bus.mem_wdata), 32'hF0);
    @(negedge clk);
    chk("lw_ack",  32'(bus.ldr_ack), 1);
    bus.ldr_req = 0; bus.ldr_we = 0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'd139;
    @(negedge clk);
    chk("cr_gnt",  32'(bus.cpu_gnt), 1);
    chk("cr_addr", 32'(bus.mem_addr), 139);
    @(negedge clk);
    chk("cr_ack",   32'(bus.cpu_ack), 1);
    chk("cr_rdata", 32'(bus.rdata), 32'hF0);
    bus.cpu_req = 0;
    @(negedge clk);
    chk_quiet("cr_idle");

    // CPU write 128 <= 6 with the request dropped during ACCESS.
    ack0 = n_cpu_ack;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'd128; bus.cpu_wdata = 8'd6;
    @(negedge clk);
    chk("dw_gnt", 32'(bus.cpu_gnt), 1);
    chk("dw_mwe", 32'(bus.mem_we), 1);
    bus.cpu_req = 0;
    @(negedge clk);
    chk("dw_ack",   32'(bus.cpu_ack), 1);
    chk("dw_stall", 32'(bus.cpu_stall), 0);
    @(negedge clk);
    chk_quiet("dw_idle");
    chk("dw_stall2", 32'(bus.cpu_stall), 0);
    @(negedge clk);
    chk_quiet("dw_nogrant");
    chk("dw_mem",    32'(mem[128]), 6);
    chk("dw_nacks",  32'(n_cpu_ack - ack0), 1);
    bus.cpu_we = 0;

    // Both requesters held after a fresh reset: the owner alternates every
    // MAX_BURST acks.
    rst = 1'b1;
    bus.cpu_req = 1; bus.cpu_addr = 8'd130;
    bus.ldr_req = 1; bus.ldr_addr = 8'd139;
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 60 && k < 16; c++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.ldr_ack) begin
        exp_ldr = FIRST_LDR ^ 1'((k / MB) % 2);
        chk($sformatf("burst_own%0d", k), 32'(bus.ldr_ack), 32'(exp_ldr));
        chk($sformatf("burst_rd%0d", k), 32'(bus.rdata), exp_ldr ? 32'hF0 : 32'h02);
        k++;
        if (k == 16) begin
          bus.cpu_req = 0; bus.ldr_req = 0;
        end
      end
    end
    chk("burst_total", 32'(k), 16);
    bus.cpu_req = 0; bus.ldr_req = 0;
    @(negedge clk);
    chk_quiet("burst_idle");

    // Reset during the ACCESS of a CPU write to 131 aborts it.
    ack0 = n_cpu_ack;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'd131; bus.cpu_wdata = 8'h55;
    @(negedge clk);
    chk("ab_gnt", 32'(bus.cpu_gnt), 1);
    rst = 1'b1; bus.cpu_req = 0;
    @(negedge clk);
    chk_quiet("ab_rst");
    chk("ab_rdata", 32'(bus.rdata), 0);
    chk("ab_stall", 32'(bus.cpu_stall), 0);
    chk("ab_maddr", 32'(bus.mem_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("ab_idle");
    chk("ab_nacks", 32'(n_cpu_ack - ack0), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
